// File: rtl/conv_pkg.sv
// Constants shared by the conv, rescale and pool stages of the CNN pipeline.
package conv_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  // Feature-map dimensions seen by each pooling layer.
  localparam int unsigned L1_FMAP_WIDTH  = 24;
  localparam int unsigned L1_FMAP_HEIGHT = 24;
  localparam int unsigned L2_FMAP_WIDTH  = 8;
  localparam int unsigned L2_FMAP_HEIGHT = 8;

  // Counter width for a 0..n-1 index. At least 2 bits, so that [w-1:1] is never empty.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w > 1) ? w : 2;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer: one synchronous write port, one asynchronous read port, no reset.
module pool_line_buf #(
  parameter int unsigned DEPTH = 12,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 max-pool, stride 2: pixels arrive in raster order, one pooled
// pixel leaves one cycle after each odd-row/odd-column accept.
module maxpool2x2_stream
  import conv_pkg::*;
#(
  parameter int unsigned BITWIDTH_DATA = DATA_WIDTH_DEF,
  parameter int unsigned IMG_WIDTH     = L1_FMAP_WIDTH,
  parameter int unsigned IMG_HEIGHT    = L1_FMAP_HEIGHT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     in_valid,
  input  logic [BITWIDTH_DATA-1:0] in_data,
  output logic                     out_valid,
  output logic [BITWIDTH_DATA-1:0] out_data,
  output logic                     frame_done
);

  localparam int unsigned CW = cnt_width(IMG_WIDTH);
  localparam int unsigned RW = cnt_width(IMG_HEIGHT);
  localparam int unsigned LB_DEPTH = IMG_WIDTH / 2;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [BITWIDTH_DATA-1:0] h_q;
  logic [BITWIDTH_DATA-1:0] pair_max;
  logic [BITWIDTH_DATA-1:0] lb_rdata;
  logic [BITWIDTH_DATA-1:0] quad_max;
  logic accept;
  logic last_col;
  logic last_row;
  logic lb_we;

  assign accept   = ena & in_valid;
  assign last_col = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row = (row_q == RW'(IMG_HEIGHT - 1));
  assign pair_max = (in_data > h_q) ? in_data : h_q;
  assign quad_max = (pair_max > lb_rdata) ? pair_max : lb_rdata;
  // Even rows park their horizontal maxima; odd rows consume them.
  assign lb_we    = accept & col_q[0] & ~row_q[0];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      h_q        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (accept) begin
        if (!col_q[0]) begin
          h_q <= in_data;
        end else if (row_q[0]) begin
          out_data   <= quad_max;
          out_valid  <= 1'b1;
          frame_done <= last_col & last_row;
        end
      end
    end
  end

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .WIDTH (BITWIDTH_DATA),
    .AW    (CW - 1)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (col_q[CW-1:1]),
    .wdata (pair_max),
    .raddr (col_q[CW-1:1]),
    .rdata (lb_rdata)
  );

endmodule
